// File: rtl/gnr_node_multi.sv
// Gene-regulatory-network node with NUM_STATES slots, per-slot update dividers,
// change pulses and a settled flag. Optional GNR_TOGGLE_CNT_EN adds per-slot toggle counters.
module gnr_node_multi #(
  parameter int unsigned NUM_STATES    = 2,
  parameter int unsigned WIDTH         = 1,
  parameter int unsigned DIV_WIDTH     = 2,
  parameter int unsigned STABLE_THRESH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          reset_nos,
  input  logic [WIDTH-1:0]              init_state,
  input  logic [NUM_STATES*DIV_WIDTH-1:0] div_cfg,
  input  logic [NUM_STATES-1:0]         start_s,
  input  logic [NUM_STATES*WIDTH-1:0]   camp_s,
  output logic [NUM_STATES*WIDTH-1:0]   s,
  output logic [NUM_STATES*WIDTH-1:0]   pka_s,
  output logic [NUM_STATES-1:0]         changed,
`ifdef GNR_TOGGLE_CNT_EN
  output logic [NUM_STATES*16-1:0]      toggle_cnt,
`endif
  output logic                          stable
);

  localparam int unsigned CNT_W = $clog2(STABLE_THRESH + 1);
  localparam int unsigned TOG_W = 16;

  logic [NUM_STATES*WIDTH-1:0] s_q, s_d;
  logic [NUM_STATES-1:0]       changed_q, changed_d;
  logic                        stable_q, stable_d;
  logic [CNT_W-1:0]            stable_cnt_q, stable_cnt_d;
  logic [DIV_WIDTH-1:0]        phase_q [NUM_STATES];
  logic [DIV_WIDTH-1:0]        phase_d [NUM_STATES];
  logic [DIV_WIDTH-1:0]        div_q   [NUM_STATES];
  logic [DIV_WIDTH-1:0]        div_d   [NUM_STATES];

  // Next-state: node re-init, then per-slot divided updates and settle tracking
  always_comb begin
    s_d          = s_q;
    changed_d    = '0;
    stable_cnt_d = stable_cnt_q;
    for (int i = 0; i < NUM_STATES; i++) begin
      phase_d[i] = phase_q[i];
      div_d[i]   = div_q[i];
    end

    if (reset_nos) begin
      s_d          = {NUM_STATES{init_state}};
      stable_cnt_d = '0;
      for (int i = 0; i < NUM_STATES; i++) begin
        phase_d[i] = '0;
        div_d[i]   = (div_cfg[i*DIV_WIDTH +: DIV_WIDTH] == '0) ? DIV_WIDTH'(1)
                                                               : div_cfg[i*DIV_WIDTH +: DIV_WIDTH];
      end
    end else begin
      for (int i = 0; i < NUM_STATES; i++) begin
        if (start_s[i]) begin
          if (phase_q[i] == '0) begin
            s_d[i*WIDTH +: WIDTH] = camp_s[i*WIDTH +: WIDTH];
            changed_d[i]          = (camp_s[i*WIDTH +: WIDTH] != s_q[i*WIDTH +: WIDTH]);
            phase_d[i]            = div_q[i] - DIV_WIDTH'(1);
          end else begin
            phase_d[i] = phase_q[i] - DIV_WIDTH'(1);
          end
        end
      end
      if (|start_s) begin
        if (|changed_d) begin
          stable_cnt_d = '0;
        end else if (stable_cnt_q < CNT_W'(STABLE_THRESH)) begin
          stable_cnt_d = stable_cnt_q + CNT_W'(1);
        end
      end
    end

    stable_d = reset_nos ? 1'b0 : (stable_cnt_d >= CNT_W'(STABLE_THRESH));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s_q          <= '0;
      changed_q    <= '0;
      stable_q     <= 1'b0;
      stable_cnt_q <= '0;
      for (int i = 0; i < NUM_STATES; i++) begin
        phase_q[i] <= '0;
        div_q[i]   <= DIV_WIDTH'(1);
      end
    end else begin
      s_q          <= s_d;
      changed_q    <= changed_d;
      stable_q     <= stable_d;
      stable_cnt_q <= stable_cnt_d;
      for (int i = 0; i < NUM_STATES; i++) begin
        phase_q[i] <= phase_d[i];
        div_q[i]   <= div_d[i];
      end
    end
  end

  assign s       = s_q;
  assign pka_s   = s_q;
  assign changed = changed_q;
  assign stable  = stable_q;

`ifdef GNR_TOGGLE_CNT_EN
  logic [TOG_W-1:0] toggle_q [NUM_STATES];
  logic [TOG_W-1:0] toggle_d [NUM_STATES];

  // Count change pulses per slot, saturating
  always_comb begin
    for (int i = 0; i < NUM_STATES; i++) begin
      toggle_d[i] = toggle_q[i];
      if (reset_nos) begin
        toggle_d[i] = '0;
      end else if (changed_d[i] && (toggle_q[i] != {TOG_W{1'b1}})) begin
        toggle_d[i] = toggle_q[i] + TOG_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_STATES; i++) toggle_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_STATES; i++) toggle_q[i] <= toggle_d[i];
    end
  end

  always_comb begin
    toggle_cnt = '0;
    for (int i = 0; i < NUM_STATES; i++) toggle_cnt[i*TOG_W +: TOG_W] = toggle_q[i];
  end
`endif

endmodule

// File: tb/tb_gnr_node_multi.sv
// Table-driven bench for gnr_node_multi (N=2, W=1, DIV_WIDTH=2, THRESH=4) with an
// expected-result queue; toggle counters checked when GNR_TOGGLE_CNT_EN is defined.
module tb_gnr_node_multi;

  logic       clk = 1'b0;
  logic       rst_n, reset_nos;
  logic [0:0] init_state;
  logic [3:0] div_cfg;
  logic [1:0] start_s, camp_s, s, pka_s, changed;
  logic       stable;
`ifdef GNR_TOGGLE_CNT_EN
  logic [31:0] toggle_cnt;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  gnr_node_multi #(.NUM_STATES(2), .WIDTH(1), .DIV_WIDTH(2), .STABLE_THRESH(4)) dut (
    .clk(clk), .rst_n(rst_n), .reset_nos(reset_nos), .init_state(init_state),
    .div_cfg(div_cfg), .start_s(start_s), .camp_s(camp_s), .s(s), .pka_s(pka_s),
    .changed(changed),
`ifdef GNR_TOGGLE_CNT_EN
    .toggle_cnt(toggle_cnt),
`endif
    .stable(stable)
  );

  typedef struct {
    logic       rst_n, reset_nos, init;
    logic [3:0] div;
    logic [1:0] start, camp;
    logic [1:0] exp_s, exp_ch;
    logic       exp_st;
  } vec_t;

  typedef struct {
    logic [1:0] s, ch;
    logic       st;
    int         idx;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  function automatic vec_t mk(logic r, logic rn, logic in, logic [3:0] d, logic [1:0] st,
                              logic [1:0] cp, logic [1:0] es, logic [1:0] ec, logic est);
    vec_t v;
    v.rst_n = r; v.reset_nos = rn; v.init = in; v.div = d; v.start = st; v.camp = cp;
    v.exp_s = es; v.exp_ch = ec; v.exp_st = est;
    return v;
  endfunction

  task automatic check(string name, int idx, logic [31:0] act, logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s vec %0d: got %0h expected %0h", name, idx, act, exp_v);
    end
  endtask

  // Drive one vector, queue its expectation, compare after the edge
  task automatic apply(vec_t v, int idx);
    exp_t e;
    @(negedge clk);
    rst_n = v.rst_n; reset_nos = v.reset_nos; init_state = v.init;
    div_cfg = v.div; start_s = v.start; camp_s = v.camp;
    e.s = v.exp_s; e.ch = v.exp_ch; e.st = v.exp_st; e.idx = idx;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      errors++; checks++;
      $display("FAIL scoreboard empty vec %0d", idx);
    end else begin
      e = sb.pop_front();
      check("s", e.idx, 32'(s), 32'(e.s));
      check("pka_s", e.idx, 32'(pka_s), 32'(e.s));
      check("changed", e.idx, 32'(changed), 32'(e.ch));
      check("stable", e.idx, 32'(stable), 32'(e.st));
    end
  endtask

  initial begin
    rst_n = 1'b0; reset_nos = 1'b0; init_state = '0; div_cfg = '0; start_s = '0; camp_s = '0;

    //           rst rn in div      start  camp   exp_s  exp_ch st
    vecs.push_back(mk(0, 0, 0, 4'b0000, 2'b00, 2'b00, 2'b00, 2'b00, 0));
    vecs.push_back(mk(0, 0, 0, 4'b0000, 2'b00, 2'b00, 2'b00, 2'b00, 0));
    vecs.push_back(mk(1, 1, 1, 4'b0000, 2'b00, 2'b00, 2'b11, 2'b00, 0));
    // divider 0 behaves as 1
    vecs.push_back(mk(1, 0, 0, 4'b0000, 2'b01, 2'b00, 2'b10, 2'b01, 0));
    vecs.push_back(mk(1, 0, 0, 4'b0000, 2'b01, 2'b01, 2'b11, 2'b01, 0));
    vecs.push_back(mk(1, 0, 0, 4'b0000, 2'b10, 2'b00, 2'b01, 2'b10, 0));
    // slot0 div 1, slot1 div 2; later div_cfg edits must be ignored
    vecs.push_back(mk(1, 1, 1, 4'b1001, 2'b00, 2'b00, 2'b11, 2'b00, 0));
    vecs.push_back(mk(1, 0, 0, 4'b1001, 2'b11, 2'b00, 2'b00, 2'b11, 0));
    vecs.push_back(mk(1, 0, 0, 4'b0000, 2'b11, 2'b11, 2'b01, 2'b01, 0));
    vecs.push_back(mk(1, 0, 0, 4'b0000, 2'b11, 2'b11, 2'b11, 2'b10, 0));
    vecs.push_back(mk(1, 0, 0, 4'b0000, 2'b11, 2'b00, 2'b10, 2'b01, 0));
    vecs.push_back(mk(1, 0, 0, 4'b0000, 2'b00, 2'b11, 2'b10, 2'b00, 0));
    // settle: four no-change updates, saturation, then a change
    vecs.push_back(mk(1, 1, 0, 4'b0101, 2'b00, 2'b00, 2'b00, 2'b00, 0));
    vecs.push_back(mk(1, 0, 0, 4'b0101, 2'b11, 2'b00, 2'b00, 2'b00, 0));
    vecs.push_back(mk(1, 0, 0, 4'b0101, 2'b11, 2'b00, 2'b00, 2'b00, 0));
    vecs.push_back(mk(1, 0, 0, 4'b0101, 2'b11, 2'b00, 2'b00, 2'b00, 0));
    vecs.push_back(mk(1, 0, 0, 4'b0101, 2'b11, 2'b00, 2'b00, 2'b00, 1));
    vecs.push_back(mk(1, 0, 0, 4'b0101, 2'b00, 2'b11, 2'b00, 2'b00, 1));
    vecs.push_back(mk(1, 0, 0, 4'b0101, 2'b11, 2'b00, 2'b00, 2'b00, 1));
    vecs.push_back(mk(1, 0, 0, 4'b0101, 2'b01, 2'b01, 2'b01, 2'b01, 0));
    // reset_nos beats start_s
    vecs.push_back(mk(1, 1, 1, 4'b0101, 2'b11, 2'b00, 2'b11, 2'b00, 0));
    vecs.push_back(mk(1, 0, 0, 4'b0101, 2'b00, 2'b00, 2'b11, 2'b00, 0));
    // rst_n mid-divide drops divider back to 1; rst_n beats reset_nos
    vecs.push_back(mk(1, 1, 0, 4'b1010, 2'b00, 2'b00, 2'b00, 2'b00, 0));
    vecs.push_back(mk(1, 0, 0, 4'b1010, 2'b11, 2'b11, 2'b11, 2'b11, 0));
    vecs.push_back(mk(0, 1, 1, 4'b1010, 2'b00, 2'b00, 2'b00, 2'b00, 0));
    vecs.push_back(mk(1, 0, 0, 4'b1010, 2'b11, 2'b11, 2'b11, 2'b11, 0));
    vecs.push_back(mk(1, 0, 0, 4'b1010, 2'b11, 2'b00, 2'b00, 2'b11, 0));

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

`ifdef GNR_TOGGLE_CNT_EN
    begin
      vec_t tv[$];
      tv.push_back(mk(1, 1, 0, 4'b0101, 2'b00, 2'b00, 2'b00, 2'b00, 0));
      tv.push_back(mk(1, 0, 0, 4'b0101, 2'b01, 2'b01, 2'b01, 2'b01, 0));
      tv.push_back(mk(1, 0, 0, 4'b0101, 2'b01, 2'b00, 2'b00, 2'b01, 0));
      tv.push_back(mk(1, 0, 0, 4'b0101, 2'b01, 2'b01, 2'b01, 2'b01, 0));
      for (int i = 0; i < tv.size(); i++) apply(tv[i], 100 + i);
      check("toggle_slot0", 103, 32'(toggle_cnt[15:0]), 32'd3);
      check("toggle_slot1", 103, 32'(toggle_cnt[31:16]), 32'd0);
      apply(mk(1, 1, 0, 4'b0101, 2'b00, 2'b00, 2'b00, 2'b00, 0), 104);
      check("toggle_clear", 104, toggle_cnt, 32'd0);
    end
`endif

    if (sb.size() != 0) begin
      errors++; checks++;
      $display("FAIL scoreboard leftover %0d entries", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
